seg_display_mux: RTL and testbench
==================================

# seg_display_mux

Seven-segment display scanner for the stopwatch datapath, fed by the `clk_div` outputs. It takes the divided `fast_clk` and `blink_clk` levels as plain data inputs and never uses them as clocks. Both are synchronized into `sys_clk`, and `fast_clk` edges step a 4-digit multiplex. The block decodes the MM:SS BCD digits to active-low segments and blanks the digit pair being adjusted at the blink rate.

## Interface
- `DP_DIGIT`, default 2: digit index (0..3) whose decimal point is lit as the MM.SS separator.
- `SCAN_BOTH_EDGES`, default 1: 1 = advance on both edges of `fast_clk` (50 Hz/digit refresh); 0 = rising edge only.
- `sys_clk`  in  1  master clock, 100 MHz.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `fast_clk`  in  1  100 Hz square wave from the divider, asynchronous to use.
- `blink_clk`  in  1  4 Hz square wave from the divider.
- `adj_en`  in  1  adjust mode active.
- `adj_sel`  in  1  0 = minutes pair blinks, 1 = seconds pair blinks.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones`  in  4 each  BCD digits.
- `an`  out  4  anode enables, active-low, one-hot-low.
- `seg`  out  8  {dp,g,f,e,d,c,b,a}, active-low.

## Operation
- Sync: `fast_clk` and `blink_clk` each pass through 2 flops (s1→s2). `fast_clk` has a third flop s3, and `tick` = s2 XOR s3 (both edges) or s2 & ~s3 (rising only).
- Scan index: 2-bit `idx` increments on `tick` and wraps 3→0.
- Digit map: idx0 → `an[0]`/`sec_ones`, idx1 → `an[1]`/`sec_tens`, idx2 → `an[2]`/`min_ones`, idx3 → `an[3]`/`min_tens`.
- Decode:
  - 0..9 → standard patterns, active-low. Examples: 0 = 7'b1000000, 8 = 7'b0000000, in {g..a} order.
  - 10..15 → dash, g lit only = 7'b0111111.
- dp (`seg[7]`) = 0 when `idx==DP_DIGIT`, else 1.
- Blink: `blank` = `adj_en` & blink_s2 & (selected pair contains `idx`). `adj_sel=1` selects idx0/1; `adj_sel=0` selects idx2/3.
- While `blank`: `an` = 4'b1111, `seg` = 8'hFF.
- Outputs registered: `an`/`seg` are recomputed every `sys_clk` from current `idx`, digit inputs and blink state. Digit-value changes appear after 1 clock, without waiting for a tick.
- Reset (async, any time): `idx`=0, all sync flops=0, `an`=4'b1111, `seg`=8'hFF.
- After reset release, the first output edge drives idx0 (`an`=4'b1110).
- If `fast_clk` is high at reset release, one spurious tick occurs (idx→1). This is accepted, not an error.
- `adj_en` or `adj_sel` change mid-blink: takes effect on the next output register update. No state is held.
- Simultaneous tick and blink edge: both apply in their own pipelines; no priority needed.

## Timing
- `fast_clk` edge → `tick`: 2 clocks (s1, s2); `idx` updates at clock 3; `an`/`seg` change at clock 4.
- `blink_clk` edge → blanking visible: 3 clocks.
- Digit/`adj_*` input change → `seg`/`an`: 1 clock.
- Exactly one `an` bit is low at any time, or none while blanked or in reset.
- Glitch-free: `an` and `seg` come straight from flops.

## Structure
- Shared package `stopwatch_pkg`:
  - `SEG_0`..`SEG_9`, `SEG_DASH`, `SEG_OFF` constants.
  - `DIG_SEC_ONES`..`DIG_MIN_TENS` index constants.
  - A `bcd_to_seg` function.
  - The divider frequency constants shared with `clk_div`.
- Sub-module `level_sync_edge` (2-flop sync + edge detect, async active-low reset), instantiated for `fast_clk` (edge used) and `blink_clk` (level used).
- Top: scan counter, mux, blank logic, output registers.

## Test plan
- Reset: hold `rst_n`=0 while toggling all inputs → `an`=1111, `seg`=FF throughout. Release with `fast_clk`=0 → `an`=1110 within 1 clock.
- Scan: digits 1,2,3,4 (min_tens..sec_ones), 8 `fast_clk` edges → `an` cycles 1110,1101,1011,0111 twice. `seg` = `SEG_4`, `SEG_3`, `SEG_2`(dp=0), `SEG_1`. Each change lands 4 clocks after its edge.
- Invalid BCD: `sec_ones`=4'hC at idx0 → `seg`=8'b10111111.
- Blink: `adj_en`=1, `adj_sel`=0, `blink_clk` high, idx=2 → `an`=1111 and `seg`=FF 3 clocks after the edge. Same with idx=0 → digit shown normally.
- Live update: change `min_ones` 5→7 while idx=2 → `seg` shows `SEG_7` with dp=0 on the next clock, `idx` unchanged.
- Async reset mid-scan at idx=3 → outputs blank within the reset cycle; resume at idx0.

Source files
------------

// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared constants for the stopwatch datapath: divider rates,
//               active-low seven-segment patterns, scan digit indices and
//               the BCD to segment decoder.
// Revision    : 1.0  initial release
// ============================================================================
package stopwatch_pkg;

   // Divider rates shared with clk_div
   localparam int unsigned SYS_CLK_HZ   = 100_000_000;
   localparam int unsigned FAST_CLK_HZ  = 100;
   localparam int unsigned BLINK_CLK_HZ = 4;
   localparam int unsigned FAST_DIV     = SYS_CLK_HZ / (2 * FAST_CLK_HZ);
   localparam int unsigned BLINK_DIV    = SYS_CLK_HZ / (2 * BLINK_CLK_HZ);

   // Active-low segment patterns in {g,f,e,d,c,b,a} order
   localparam logic [6:0] SEG_0    = 7'b1000000;
   localparam logic [6:0] SEG_1    = 7'b1111001;
   localparam logic [6:0] SEG_2    = 7'b0100100;
   localparam logic [6:0] SEG_3    = 7'b0110000;
   localparam logic [6:0] SEG_4    = 7'b0011001;
   localparam logic [6:0] SEG_5    = 7'b0010010;
   localparam logic [6:0] SEG_6    = 7'b0000010;
   localparam logic [6:0] SEG_7    = 7'b1111000;
   localparam logic [6:0] SEG_8    = 7'b0000000;
   localparam logic [6:0] SEG_9    = 7'b0010000;
   localparam logic [6:0] SEG_DASH = 7'b0111111;
   localparam logic [6:0] SEG_OFF  = 7'b1111111;

   // Scan positions, rightmost digit first
   localparam logic [1:0] DIG_SEC_ONES = 2'd0;
   localparam logic [1:0] DIG_SEC_TENS = 2'd1;
   localparam logic [1:0] DIG_MIN_ONES = 2'd2;
   localparam logic [1:0] DIG_MIN_TENS = 2'd3;

   // Non-decimal codes show a dash so a corrupted digit is visible
   function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
      logic [6:0] pat;
      case (bcd)
         4'd0:    pat = SEG_0;
         4'd1:    pat = SEG_1;
         4'd2:    pat = SEG_2;
         4'd3:    pat = SEG_3;
         4'd4:    pat = SEG_4;
         4'd5:    pat = SEG_5;
         4'd6:    pat = SEG_6;
         4'd7:    pat = SEG_7;
         4'd8:    pat = SEG_8;
         4'd9:    pat = SEG_9;
         default: pat = SEG_DASH;
      endcase
      return pat;
   endfunction

endpackage
`default_nettype wire

// File: rtl/level_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : level_sync_edge
// Description : Two-flop synchronizer for a slow asynchronous level plus a
//               third flop for single-cycle edge detection.
// Revision    : 1.0  initial release
// ============================================================================
module level_sync_edge #(
   parameter bit BOTH_EDGES = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic level,
   output logic edge_pulse
);

   logic s1;
   logic s2;
   logic s3;

   // Synchronizer chain; s3 holds the previous synchronized level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= async_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign level = s2;

   generate
      if (BOTH_EDGES) begin : g_both_edges
         assign edge_pulse = s2 ^ s3;
      end else begin : g_rise_edge
         assign edge_pulse = s2 & ~s3;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/seg_display_mux.sv
`default_nettype none
// ============================================================================
// Module      : seg_display_mux
// Description : Four-digit MM:SS seven-segment scanner. Steps the digit on
//               synchronized fast_clk edges, decodes BCD to active-low
//               segments and blanks the pair under adjustment at the blink
//               rate. All outputs come straight from flops.
// Revision    : 1.0  initial release
// ============================================================================
module seg_display_mux
   import stopwatch_pkg::*;
#(
   parameter int unsigned DP_DIGIT        = 2,
   parameter bit          SCAN_BOTH_EDGES = 1'b1
) (
   input  logic       sys_clk,
   input  logic       rst_n,
   input  logic       fast_clk,
   input  logic       blink_clk,
   input  logic       adj_en,
   input  logic       adj_sel,
   input  logic [3:0] min_tens,
   input  logic [3:0] min_ones,
   input  logic [3:0] sec_tens,
   input  logic [3:0] sec_ones,
   output logic [3:0] an,
   output logic [7:0] seg
);

   localparam logic [1:0] DP_IDX = DP_DIGIT[1:0];

   logic       tick;
   logic       blink_lvl;
   logic       fast_lvl_unused;
   logic       blink_edge_unused;
   logic [1:0] idx;
   logic [3:0] digit;
   logic       blank;
   logic [3:0] an_next;
   logic [7:0] seg_next;

   level_sync_edge #(
      .BOTH_EDGES (SCAN_BOTH_EDGES)
   ) u_fast_sync (
      .clk        (sys_clk),
      .rst_n      (rst_n),
      .async_in   (fast_clk),
      .level      (fast_lvl_unused),
      .edge_pulse (tick)
   );

   level_sync_edge #(
      .BOTH_EDGES (1'b1)
   ) u_blink_sync (
      .clk        (sys_clk),
      .rst_n      (rst_n),
      .async_in   (blink_clk),
      .level      (blink_lvl),
      .edge_pulse (blink_edge_unused)
   );

   // Scan index advances once per synchronized fast_clk edge, wrapping 3 -> 0
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         idx <= DIG_SEC_ONES;
      end else if (tick) begin
         idx <= idx + 2'd1;
      end
   end

   // Select the digit for the current position and form the next outputs
   always_comb begin
      digit    = sec_ones;
      blank    = 1'b0;
      an_next  = 4'b1111;
      seg_next = {1'b1, SEG_OFF};
      case (idx)
         DIG_SEC_ONES: digit = sec_ones;
         DIG_SEC_TENS: digit = sec_tens;
         DIG_MIN_ONES: digit = min_ones;
         DIG_MIN_TENS: digit = min_tens;
         default:      digit = sec_ones;
      endcase
      // adj_sel high picks the seconds pair (idx 0/1), low the minutes pair
      blank = adj_en & blink_lvl & (adj_sel ? ~idx[1] : idx[1]);
      if (!blank) begin
         an_next  = ~(4'b0001 << idx);
         seg_next = {(idx != DP_IDX), bcd_to_seg(digit)};
      end
   end

   // Output registers keep an/seg glitch-free for the display pins
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         an  <= 4'b1111;
         seg <= 8'hFF;
      end else begin
         an  <= an_next;
         seg <= seg_next;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seg_display_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_display_mux
// Description : Self-checking bench for seg_display_mux with a behavioural
//               reference model built from the latency rules of the display.
// Revision    : 1.0  initial release
// ============================================================================
module tb_seg_display_mux;

   localparam bit SCAN_BOTH = 1'b1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       fast_clk;
   logic       blink_clk;
   logic       adj_en;
   logic       adj_sel;
   logic [3:0] min_tens;
   logic [3:0] min_ones;
   logic [3:0] sec_tens;
   logic [3:0] sec_ones;
   logic [3:0] an;
   logic [7:0] seg;

   int n_checks = 0;
   int n_fail   = 0;

   seg_display_mux #(
      .DP_DIGIT        (2),
      .SCAN_BOTH_EDGES (SCAN_BOTH)
   ) dut (
      .sys_clk   (clk),
      .rst_n     (rst_n),
      .fast_clk  (fast_clk),
      .blink_clk (blink_clk),
      .adj_en    (adj_en),
      .adj_sel   (adj_sel),
      .min_tens  (min_tens),
      .min_ones  (min_ones),
      .sec_tens  (sec_tens),
      .sec_ones  (sec_ones),
      .an        (an),
      .seg       (seg)
   );

   always #5 clk = ~clk;

   // Reference model: a fast_clk change sampled at edge k moves the shown
   // digit at edge k+3; blink level sampled at edge k is applied at edge k+2.
   logic [6:0] lit_tbl [16];
   int         edge_n;
   bit         fast_prev;
   int         adv_q[$];
   bit         blink_hist[$];
   int         m_idx;
   bit         blink_seen;
   logic [3:0] dig_of [4];
   logic [3:0] exp_an;
   logic [7:0] exp_seg;

   initial begin
      // active-high lit segments {g..a}: digits, then dash for 10..15
      lit_tbl[0] = 7'h3F; lit_tbl[1] = 7'h06; lit_tbl[2] = 7'h5B; lit_tbl[3] = 7'h4F;
      lit_tbl[4] = 7'h66; lit_tbl[5] = 7'h6D; lit_tbl[6] = 7'h7D; lit_tbl[7] = 7'h07;
      lit_tbl[8] = 7'h7F; lit_tbl[9] = 7'h6F;
      for (int i = 10; i < 16; i++) lit_tbl[i] = 7'h40;
   end

   always @(posedge clk) begin
      if (!rst_n) begin
         edge_n    = 0;
         fast_prev = 1'b0;
         adv_q.delete();
         blink_hist.delete();
         m_idx     = 0;
         exp_an    = 4'hF;
         exp_seg   = 8'hFF;
      end else begin
         edge_n++;
         if (fast_clk != fast_prev && (SCAN_BOTH || fast_clk)) adv_q.push_back(edge_n + 3);
         fast_prev = fast_clk;
         blink_hist.push_back(blink_clk);
         while (adv_q.size() > 0 && adv_q[0] <= edge_n) begin
            void'(adv_q.pop_front());
            m_idx = (m_idx + 1) % 4;
         end
         blink_seen = (edge_n >= 3) ? blink_hist[edge_n - 3] : 1'b0;
         dig_of[0] = sec_ones; dig_of[1] = sec_tens;
         dig_of[2] = min_ones; dig_of[3] = min_tens;
         if (adj_en && blink_seen && (adj_sel ? (m_idx < 2) : (m_idx >= 2))) begin
            exp_an  = 4'hF;
            exp_seg = 8'hFF;
         end else begin
            exp_an  = 4'hF;
            exp_an[m_idx] = 1'b0;
            exp_seg = {(m_idx != 2), ~lit_tbl[dig_of[m_idx]]};
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at t=%0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   // One clock, then compare both outputs against the model
   task automatic step();
      @(posedge clk);
      #1;
      check_eq("an", {28'd0, an}, {28'd0, exp_an});
      check_eq("seg", {24'd0, seg}, {24'd0, exp_seg});
   endtask

   // Toggle fast_clk until the model shows the wanted digit (bounded)
   task automatic wait_idx(input int target);
      for (int i = 0; i < 8 && m_idx != target; i++) begin
         fast_clk = ~fast_clk;
         repeat (4) step();
      end
      check_eq("wait_idx", {31'd0, m_idx == target}, 32'd1);
   endtask

   initial begin
      rst_n = 1'b0; fast_clk = 1'b0; blink_clk = 1'b0;
      adj_en = 1'b0; adj_sel = 1'b0;
      min_tens = 4'd0; min_ones = 4'd0; sec_tens = 4'd0; sec_ones = 4'd0;

      // Reset held while inputs toggle: display stays dark
      for (int i = 0; i < 6; i++) begin
         fast_clk = 1'($urandom); blink_clk = 1'($urandom);
         adj_en = 1'($urandom); adj_sel = 1'($urandom);
         min_tens = 4'($urandom); min_ones = 4'($urandom);
         sec_tens = 4'($urandom); sec_ones = 4'($urandom);
         @(posedge clk); #1;
         check_eq("rst_an", {28'd0, an}, 32'hF);
         check_eq("rst_seg", {24'd0, seg}, 32'hFF);
      end

      // Release with fast_clk low: idx0 on the first edge
      fast_clk = 1'b0; blink_clk = 1'b0; adj_en = 1'b0;
      min_tens = 4'd1; min_ones = 4'd2; sec_tens = 4'd3; sec_ones = 4'd4;
      rst_n = 1'b1;
      step();
      check_eq("rel_an", {28'd0, an}, 32'hE);
      check_eq("rel_seg", {24'd0, seg}, {24'd0, 8'b10011001});

      // Scan through two full rounds
      for (int e = 0; e < 8; e++) begin
         fast_clk = ~fast_clk;
         repeat (6) step();
      end

      // Invalid BCD shows a dash
      wait_idx(0);
      sec_ones = 4'hC;
      step();
      check_eq("bad_bcd", {24'd0, seg}, {24'd0, 8'b10111111});

      // Live digit update with scan frozen on idx2
      wait_idx(2);
      min_ones = 4'd5;
      step();
      min_ones = 4'd7;
      step();
      check_eq("live_seg", {24'd0, seg}, {24'd0, 8'b01111000});
      check_eq("live_an", {28'd0, an}, 32'hB);

      // Minutes pair blinks: dark 3 clocks after the blink edge
      adj_en = 1'b1; adj_sel = 1'b0;
      blink_clk = 1'b1;
      step();
      step();
      check_eq("blink_early", {28'd0, an}, 32'hB);
      step();
      check_eq("blink_an", {28'd0, an}, 32'hF);
      check_eq("blink_seg", {24'd0, seg}, 32'hFF);
      wait_idx(0);
      check_eq("blink_other", {28'd0, an}, 32'hE);

      // Randomized operation
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 4) == 0) fast_clk = ~fast_clk;
         if ($urandom_range(0, 39) == 0) blink_clk = ~blink_clk;
         if ($urandom_range(0, 29) == 0) adj_en = 1'($urandom);
         if ($urandom_range(0, 29) == 0) adj_sel = 1'($urandom);
         if ($urandom_range(0, 9) == 0) begin
            case ($urandom_range(0, 3))
               0: min_tens = 4'($urandom_range(0, 15));
               1: min_ones = 4'($urandom_range(0, 15));
               2: sec_tens = 4'($urandom_range(0, 15));
               default: sec_ones = 4'($urandom_range(0, 15));
            endcase
         end
         step();
      end

      // Asynchronous reset mid-scan at idx3
      adj_en = 1'b0;
      wait_idx(3);
      #2 rst_n = 1'b0;
      #1;
      check_eq("async_an", {28'd0, an}, 32'hF);
      check_eq("async_seg", {24'd0, seg}, 32'hFF);
      fast_clk = 1'b0;
      repeat (2) step();
      #1 rst_n = 1'b1;
      step();
      check_eq("resume_an", {28'd0, an}, 32'hE);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
